// File: rtl/traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// traffic_phase_sequencer
//
// Purpose:
//   Consumer end of the slow-clock interface. The divided 1 Hz square wave is
//   brought into the clk domain through a two-flop synchroniser. A third flop
//   provides rising-edge detection, which yields a one-clk "second tick".
//   The ticks time a two-road (main/side) intersection through its light
//   phases. A watchdog forces an all-red FAULT state if the ticks stop. The
//   sequencer leaves FAULT by itself after a run of consecutive on-time
//   ticks.
//
// Ports:
//   clk          in   1  fast system clock
//   rst          in   1  asynchronous, active-high reset
//   slow_clk_in  in   1  divided square wave, asynchronous to clk
//   side_req     in   1  side-road vehicle request (level, clk-synchronous)
//   main_light   out  3  {red,yellow,green} for main road, one-hot
//   side_light   out  3  {red,yellow,green} for side road, one-hot
//   sec_tick     out  1  one-clk pulse per slow_clk_in rising edge
//   fault        out  1  high while in FAULT
//   state_o      out  3  current state encoding
// ---------------------------------------------------------------------------
module traffic_phase_sequencer #(
  parameter int GREEN_SECS    = 10,
  parameter int YELLOW_SECS   = 3,
  parameter int ALL_RED_SECS  = 1,
  parameter int TICK_TIMEOUT  = 60000000,
  parameter int RECOVER_TICKS = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       slow_clk_in,
  input  logic       side_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       sec_tick,
  output logic       fault,
  output logic [2:0] state_o
);

  // State encodings
  localparam logic [2:0] ST_MAIN_GREEN  = 3'd0;
  localparam logic [2:0] ST_MAIN_YELLOW = 3'd1;
  localparam logic [2:0] ST_ALL_RED_1   = 3'd2;
  localparam logic [2:0] ST_SIDE_GREEN  = 3'd3;
  localparam logic [2:0] ST_SIDE_YELLOW = 3'd4;
  localparam logic [2:0] ST_ALL_RED_2   = 3'd5;
  localparam logic [2:0] ST_FAULT       = 3'd6;

  // Light patterns, {red,yellow,green}
  localparam logic [2:0] LT_RED = 3'b100;
  localparam logic [2:0] LT_YEL = 3'b010;
  localparam logic [2:0] LT_GRN = 3'b001;

  // Terminal counts. A phase of D ticks ends on the tick seen with
  // sec_cnt == D-1.
  localparam logic [7:0]  GREEN_LAST   = 8'(GREEN_SECS - 1);
  localparam logic [7:0]  YELLOW_LAST  = 8'(YELLOW_SECS - 1);
  localparam logic [7:0]  ALL_RED_LAST = 8'(ALL_RED_SECS - 1);
  localparam logic [31:0] WD_LAST      = 32'(TICK_TIMEOUT - 1);
  localparam logic [3:0]  REC_TARGET   = 4'(RECOVER_TICKS);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic        r_s1;
  logic        r_s2;
  logic        r_s3;
  logic [2:0]  r_state;
  logic [7:0]  r_sec_cnt;
  logic [31:0] r_wd_cnt;
  logic [3:0]  r_rec_cnt;
  logic        r_pending;

  logic [2:0]  w_state_next;
  logic [7:0]  w_sec_next;
  logic [31:0] w_wd_next;
  logic [3:0]  w_rec_next;
  logic        w_pending_next;

  logic        w_tick;
  logic        w_wd_expire;
  logic [7:0]  w_dur_last;
  logic [2:0]  w_state_succ;
  logic [3:0]  w_rec_inc;
  logic        w_enter_side_green;

  // -------------------------------------------------------------------------
  // Synchroniser and rising-edge detect
  // r_s1/r_s2 form the metastability chain. r_s3 is the previous
  // synchronised value, so the tick is one clk wide per rising edge.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
      r_s3 <= 1'b0;
    end else begin
      r_s1 <= slow_clk_in;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_tick = r_s2 & ~r_s3;

  // A tick arriving on the same cycle as the watchdog limit counts as on
  // time, so expiry is qualified with the absence of a tick.
  assign w_wd_expire = (r_wd_cnt == WD_LAST) && !w_tick;

  assign w_rec_inc = r_rec_cnt + 4'd1;

  // -------------------------------------------------------------------------
  // Per-state phase length and successor
  // -------------------------------------------------------------------------
  always_comb begin
    w_dur_last   = GREEN_LAST;
    w_state_succ = ST_FAULT;
    case (r_state)
      ST_MAIN_GREEN: begin
        w_dur_last   = GREEN_LAST;
        w_state_succ = ST_MAIN_YELLOW;
      end
      ST_MAIN_YELLOW: begin
        w_dur_last   = YELLOW_LAST;
        w_state_succ = ST_ALL_RED_1;
      end
      ST_ALL_RED_1: begin
        w_dur_last   = ALL_RED_LAST;
        w_state_succ = ST_SIDE_GREEN;
      end
      ST_SIDE_GREEN: begin
        w_dur_last   = GREEN_LAST;
        w_state_succ = ST_SIDE_YELLOW;
      end
      ST_SIDE_YELLOW: begin
        w_dur_last   = YELLOW_LAST;
        w_state_succ = ST_ALL_RED_2;
      end
      ST_ALL_RED_2: begin
        w_dur_last   = ALL_RED_LAST;
        w_state_succ = ST_MAIN_GREEN;
      end
      default: begin
        // FAULT and the unused code 7 have no timed successor.
        w_dur_last   = GREEN_LAST;
        w_state_succ = ST_FAULT;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_sec_next   = r_sec_cnt;
    w_rec_next   = r_rec_cnt;

    // The watchdog restarts on every tick and also on its own expiry.
    // Restarting on expiry lets it keep clearing recovery progress while the
    // design is parked in FAULT.
    if (w_tick || w_wd_expire) begin
      w_wd_next = 32'd0;
    end else begin
      w_wd_next = r_wd_cnt + 32'd1;
    end

    if (w_wd_expire) begin
      w_state_next = ST_FAULT;
      w_sec_next   = 8'd0;
      w_rec_next   = 4'd0;
    end else if (r_state == 3'd7) begin
      // Unused encoding: fail safe to all-red.
      w_state_next = ST_FAULT;
      w_sec_next   = 8'd0;
      w_rec_next   = 4'd0;
    end else if (w_tick) begin
      if (r_state == ST_FAULT) begin
        if (w_rec_inc == REC_TARGET) begin
          w_state_next = ST_ALL_RED_2;
          w_sec_next   = 8'd0;
          w_rec_next   = 4'd0;
        end else begin
          w_rec_next   = w_rec_inc;
        end
      end else if (r_sec_cnt == w_dur_last) begin
        if (r_state == ST_MAIN_GREEN && !r_pending) begin
          // Main road keeps green with no side demand. The counter stays
          // parked at its terminal value so the first tick after a request
          // moves on immediately.
          w_sec_next   = GREEN_LAST;
        end else begin
          w_state_next = w_state_succ;
          w_sec_next   = 8'd0;
        end
      end else begin
        w_sec_next     = r_sec_cnt + 8'd1;
      end
    end
  end

  // A request that is present on the same edge as SIDE_GREEN entry survives.
  // That request is then served on the next cycle.
  assign w_enter_side_green = (w_state_next == ST_SIDE_GREEN) &&
                              (r_state != ST_SIDE_GREEN);
  assign w_pending_next     = side_req | (r_pending & ~w_enter_side_green);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_MAIN_GREEN;
      r_sec_cnt <= 8'd0;
      r_wd_cnt  <= 32'd0;
      r_rec_cnt <= 4'd0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_sec_cnt <= w_sec_next;
      r_wd_cnt  <= w_wd_next;
      r_rec_cnt <= w_rec_next;
      r_pending <= w_pending_next;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs. Lights decode straight from state so they switch on the same
  // edge as the state itself.
  // -------------------------------------------------------------------------
  always_comb begin
    main_light = LT_RED;
    side_light = LT_RED;
    case (r_state)
      ST_MAIN_GREEN: begin
        main_light = LT_GRN;
        side_light = LT_RED;
      end
      ST_MAIN_YELLOW: begin
        main_light = LT_YEL;
        side_light = LT_RED;
      end
      ST_SIDE_GREEN: begin
        main_light = LT_RED;
        side_light = LT_GRN;
      end
      ST_SIDE_YELLOW: begin
        main_light = LT_RED;
        side_light = LT_YEL;
      end
      default: begin
        main_light = LT_RED;
        side_light = LT_RED;
      end
    endcase
  end

  assign sec_tick = w_tick;
  assign fault    = (r_state == ST_FAULT);
  assign state_o  = r_state;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// ---------------------------------------------------------------------------
// tb_traffic_phase_sequencer
//
// Directed bench with GREEN=3, YELLOW=2, ALL_RED=1, TICK_TIMEOUT=40 and
// RECOVER_TICKS=2. slow_clk_in runs with a 20-clk period (10 high, 10 low).
// Inputs change on the falling clk edge. Outputs are sampled on the falling
// edge.
// ---------------------------------------------------------------------------
module tb_traffic_phase_sequencer;

  logic       clk;
  logic       rst;
  logic       slow_clk_in;
  logic       side_req;
  logic [2:0] main_light;
  logic [2:0] side_light;
  logic       sec_tick;
  logic       fault;
  logic [2:0] state_o;

  int errors = 0;
  int checks = 0;
  int tick_cycles = 0;
  int tick_pulses = 0;
  logic tick_prev = 1'b0;

  traffic_phase_sequencer #(
    .GREEN_SECS   (3),
    .YELLOW_SECS  (2),
    .ALL_RED_SECS (1),
    .TICK_TIMEOUT (40),
    .RECOVER_TICKS(2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .slow_clk_in(slow_clk_in),
    .side_req   (side_req),
    .main_light (main_light),
    .side_light (side_light),
    .sec_tick   (sec_tick),
    .fault      (fault),
    .state_o    (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Tick monitor: the number of tick cycles must equal the number of tick
  // pulses, so that every tick is exactly one clk wide.
  always @(negedge clk) begin
    if (sec_tick) tick_cycles <= tick_cycles + 1;
    if (sec_tick && !tick_prev) tick_pulses <= tick_pulses + 1;
    tick_prev <= sec_tick;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "simulation time limit reached");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s = %0h", tag, obs);
    end
  endtask

  task automatic clk_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expected {main,side} lights for a given state code.
  function automatic logic [5:0] exp_lights(input int st);
    case (st)
      0:       return 6'b001_100;
      1:       return 6'b010_100;
      3:       return 6'b100_001;
      4:       return 6'b100_010;
      default: return 6'b100_100;
    endcase
  endfunction

  // One slow_clk_in period. The optional side_req pulse lands on the clk
  // edge that comes just before the tick is presented.
  task automatic slow_period(input bit req_pulse);
    slow_clk_in = 1'b1;
    clk_n(1);
    if (req_pulse) side_req = 1'b1;
    clk_n(1);
    if (req_pulse) side_req = 1'b0;
    clk_n(8);
    slow_clk_in = 1'b0;
    clk_n(10);
  endtask

  task automatic check_state(input string tag, input int st);
    check_val(tag, {29'd0, state_o}, st);
    check_val({tag, "_lights"}, {26'd0, main_light, side_light}, {26'd0, exp_lights(st)});
  endtask

  int t0;
  int p0;
  int exp3 [12] = '{0, 0, 1, 1, 2, 3, 3, 3, 4, 4, 5, 0};
  int exp5 [6]  = '{0, 0, 1, 1, 2, 3};

  initial begin
    rst = 1'b1;
    slow_clk_in = 1'b0;
    side_req = 1'b0;
    clk_n(3);
    check_state("reset_state", 0);
    check_val("reset_tick", {31'd0, sec_tick}, 0);
    check_val("reset_fault", {31'd0, fault}, 0);
    rst = 1'b0;
    clk_n(2);

    // 1: idle main green for 10 ticks
    t0 = tick_cycles;
    p0 = tick_pulses;
    for (int i = 0; i < 10; i++) begin
      slow_period(1'b0);
      check_val($sformatf("t1_state_%0d", i + 1), {29'd0, state_o}, 0);
    end
    check_state("t1_end", 0);
    check_val("t1_tick_cycles", tick_cycles - t0, 10);
    check_val("t1_tick_pulses", tick_pulses - p0, 10);

    // 2: tick latency, held-high input, watchdog fault
    t0 = tick_cycles;
    slow_clk_in = 1'b1;
    clk_n(1);
    check_val("t2_tick_k1", {31'd0, sec_tick}, 0);
    clk_n(1);
    check_val("t2_tick_k2", {31'd0, sec_tick}, 1);
    clk_n(1);
    check_val("t2_tick_k3", {31'd0, sec_tick}, 0);
    clk_n(39);
    check_val("t2_fault_early", {31'd0, fault}, 0);
    clk_n(1);
    check_val("t2_fault", {31'd0, fault}, 1);
    check_state("t2_fault_state", 6);
    clk_n(57);
    check_val("t2_one_tick", tick_cycles - t0, 1);
    slow_clk_in = 1'b0;
    clk_n(10);
    slow_period(1'b0);
    check_state("t2_rec1", 6);
    slow_period(1'b0);
    check_state("t2_rec2", 5);
    slow_period(1'b0);
    check_state("t2_rec3", 0);
    check_val("t2_fault_clear", {31'd0, fault}, 0);

    // 3: single request pulse, full cycle
    for (int i = 0; i < 12; i++) begin
      slow_period(i == 0);
      check_state($sformatf("t3_tick%0d", i + 1), exp3[i]);
      if (i == 4) check_val("t3_pend_before", {31'd0, dut.r_pending}, 1);
      if (i == 5) check_val("t3_pend_cleared", {31'd0, dut.r_pending}, 0);
    end

    // 5 (first half): request held through SIDE_GREEN entry
    side_req = 1'b1;
    for (int i = 0; i < 6; i++) begin
      slow_period(1'b0);
      check_state($sformatf("t5_tick%0d", i + 1), exp5[i]);
    end
    check_val("t5_pend_held", {31'd0, dut.r_pending}, 1);
    side_req = 1'b0;
    slow_period(1'b0);
    check_state("t5_tick7", 3);

    // 4: slow clock stops mid SIDE_GREEN
    clk_n(22);
    check_state("t4_pre_fault", 3);
    clk_n(1);
    check_val("t4_fault", {31'd0, fault}, 1);
    check_state("t4_fault_state", 6);
    slow_period(1'b0);
    check_state("t4_rec1", 6);
    slow_period(1'b0);
    check_state("t4_rec2", 5);
    slow_period(1'b0);
    check_state("t4_rec3", 0);
    check_val("t4_fault_clear", {31'd0, fault}, 0);
    check_val("t4_pend_kept", {31'd0, dut.r_pending}, 1);

    // 5 (second half): retained request serves main green of exactly 3 ticks
    slow_period(1'b0);
    check_state("t5_mg1", 0);
    slow_period(1'b0);
    check_state("t5_mg2", 0);
    slow_period(1'b0);
    check_state("t5_mg3", 1);

    // 6: asynchronous reset mid MAIN_YELLOW
    #2;
    rst = 1'b1;
    #1;
    check_state("t6_async_rst", 0);
    check_val("t6_fault", {31'd0, fault}, 0);
    check_val("t6_pend", {31'd0, dut.r_pending}, 0);
    @(negedge clk);
    rst = 1'b0;
    clk_n(2);
    for (int i = 0; i < 6; i++) begin
      slow_period(1'b0);
      check_state($sformatf("t6_hold%0d", i + 1), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/traffic_phase_sequencer.md
Name: traffic_phase_sequencer

Overview:
Consumer end of the slow-clock interface. It takes the divided 1 Hz square wave, synchronises it into the fast clk domain, and edge-detects it into one-cycle second ticks. It then sequences a two-road intersection (main/side) through timed light phases. A watchdog forces a safe all-red FAULT state if the slow clock stops, and recovers automatically once the slow clock returns.

Parameters:
GREEN_SECS, 10, minimum green time per direction in ticks (1..255)
YELLOW_SECS, 3, yellow time per direction in ticks (1..255)
ALL_RED_SECS, 1, all-red clearance time in ticks (1..255)
TICK_TIMEOUT, 60000000, clk cycles without a tick before FAULT (≥2)
RECOVER_TICKS, 2, consecutive on-time ticks needed to leave FAULT (1..15)

Ports:
clk  input  1  fast system clock
rst  input  1  reset, asynchronous, active-high
slow_clk_in  input  1  divided square wave, treated as asynchronous to clk
side_req  input  1  side-road vehicle request, level, synchronous to clk
main_light  output  3  {red,yellow,green} for main road, one-hot
side_light  output  3  {red,yellow,green} for side road, one-hot
sec_tick  output  1  one-clk pulse per slow_clk_in rising edge
fault  output  1  high while in FAULT
state_o  output  3  current state encoding

Behaviour:
- Reset (async, active-high) clears everything:
  - s1/s2/s3, sec_cnt (8b), wd_cnt (32b), rec_cnt (4b), pending all to 0.
  - State = MAIN_GREEN, main_light=001, side_light=100, sec_tick=0, fault=0.
- Synchroniser and edge detect: s1<=slow_clk_in, s2<=s1, s3<=s2; sec_tick = s2 & ~s3 (combinational).
  - slow_clk_in first sampled high at edge k gives sec_tick high between edges k+1 and k+2.
  - FSM acts on edge k+2.
  - Falling edges produce no tick; a held-high input produces exactly one tick.
- State encoding: MAIN_GREEN=0, MAIN_YELLOW=1, ALL_RED_1=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALL_RED_2=5, FAULT=6. Codes 7 and 0..6 are the only encodings; 7 is unreachable and, if ever decoded, goes to FAULT.
- Light decode is combinational from state, so lights change in the same cycle the state changes.
  - MAIN_GREEN: main=001, side=100.
  - MAIN_YELLOW: main=010, side=100.
  - ALL_RED_x and FAULT: both 100.
  - SIDE_GREEN: main=100, side=001.
  - SIDE_YELLOW: main=100, side=010.
- Phase timing, per tick, with D = duration of the current state:
  - If sec_cnt==D-1: advance to next state, sec_cnt<=0. Otherwise sec_cnt<=sec_cnt+1.
  - No change on cycles without a tick.
- Sequence: MAIN_GREEN→MAIN_YELLOW→ALL_RED_1→SIDE_GREEN→SIDE_YELLOW→ALL_RED_2→MAIN_GREEN.
- MAIN_GREEN hold: on expiry with pending=0, stay in MAIN_GREEN and hold sec_cnt at GREEN_SECS-1. The first later tick with pending=1 advances.
- pending is a request latch:
  - Set on any clk with side_req=1.
  - Cleared on the edge entering SIDE_GREEN.
  - Set has priority over clear on the same edge.
- Watchdog: wd_cnt resets to 0 on each tick and increments otherwise.
  - At wd_cnt==TICK_TIMEOUT-1 with no tick that cycle: enter FAULT from any state, with wd_cnt<=0, rec_cnt<=0, sec_cnt<=0.
  - A tick coincident with expiry wins, and no fault occurs.
- FAULT:
  - Each tick increments rec_cnt. A watchdog expiry inside FAULT clears rec_cnt.
  - When rec_cnt reaches RECOVER_TICKS on a tick: go to ALL_RED_2 with sec_cnt=0. Normal timing then resumes to MAIN_GREEN.
  - pending is retained through FAULT.
- Reset mid-operation returns to the reset state immediately, regardless of phase.

Test Plan:
Common settings: GREEN=3, YELLOW=2, ALL_RED=1, TICK_TIMEOUT=40, RECOVER_TICKS=2, slow_clk_in period 20 clk (10 high/10 low).

1. Reset, side_req=0, run 10 ticks -> state_o=0 throughout, main_light=001, side_light=100, sec_tick pulses exactly 10 times, each 1 clk wide.
2. slow_clk_in first sampled high at edge k -> sec_tick high only between edges k+1 and k+2. Hold slow_clk_in high 100 clk -> exactly one tick and, since no tick follows, FAULT after 40 clk.
3. side_req pulsed 1 clk before tick 1 -> state goes 1 after tick 3, 2 after tick 5, 3 after tick 6, 4 after tick 9, 5 after tick 11, 0 after tick 12. pending is cleared on entry to 3.
4. Stop slow_clk_in mid SIDE_GREEN -> fault=1, state_o=6, both lights 100 exactly 40 clk after the last tick. Restart -> state 5 on the 2nd tick, state 0 on the next tick, fault=0.
5. side_req held high through SIDE_GREEN entry -> pending stays 1. After returning to MAIN_GREEN, MAIN_YELLOW follows after exactly 3 ticks.
6. rst asserted asynchronously mid MAIN_YELLOW (between clk edges) -> main=001, side=100, state_o=0, fault=0 immediately. pending=0, and MAIN_GREEN holds indefinitely with no request.
